gray2bin_pipe: RTL and testbench

- Pipelined Gray-to-binary decoder; the inverse of the team's registered binary-to-Gray encoder.
- Consumes Gray-coded values, e.g. FIFO pointers after clock-domain crossing, and produces binary values.
- Uses a valid/ready handshake with backpressure.
- Also checks each accepted Gray sample against the previously accepted one. A sample that differs from its predecessor in more than one bit is flagged as a step error (a corrupted or mis-sampled pointer).

---
 rtl/gray2bin_pipe.sv | 107 ++++++++++
 tb/tb_gray2bin_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray2bin_pipe.sv
// Pipelined Gray-to-binary decoder with valid/ready flow control and a check that
// consecutive accepted Gray samples differ in at most one bit.
module gray2bin_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_err
);

    // Bits decoded per stage, MSB-first; trailing stages may decode nothing.
    localparam int CHUNK = int'((WIDTH + STAGES - 1) / STAGES);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Resolve bits hi..lo of a word whose bits above hi are already binary.
    function automatic logic [WIDTH-1:0] decode_slice(input logic [WIDTH-1:0] word,
                                                      input int hi, input int lo);
        logic [WIDTH-1:0] res;
        res = word;
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) res[i] = res[i+1] ^ res[i];
        end
        return res;
    endfunction

    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0]            err_q;
    logic [STAGES-1:0][WIDTH-1:0] data_q;
    logic [STAGES-1:0]            en;
    logic [STAGES-1:0]            valid_in;
    logic [STAGES-1:0]            err_in;
    logic [STAGES-1:0][WIDTH-1:0] stage_in;
    logic [WIDTH-1:0]             prev_q;
    logic                         prev_vld_q;
    logic [WIDTH-1:0]             diff;
    logic                         in_err;
    logic                         in_fire;

    // A stage loads when it is empty or its content moves on in the same cycle.
    always_comb begin
        en = '0;
        en[STAGES-1] = ~valid_q[STAGES-1] | out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            en[k] = ~valid_q[k] | en[k+1];
        end
    end

    always_comb begin
        diff     = gray_in ^ prev_q;
        // More than one bit set <=> clearing the lowest set bit leaves something.
        in_err   = prev_vld_q & (|(diff & (diff - ONE)));
        in_ready = sys_rst_n & en[0];
        in_fire  = in_valid & in_ready;
    end

    always_comb begin
        stage_in    = '0;
        valid_in    = '0;
        err_in      = '0;
        stage_in[0] = decode_slice(gray_in, int'(WIDTH) - 1, int'(WIDTH) - CHUNK);
        valid_in[0] = in_valid;
        err_in[0]   = in_err;
        for (int k = 1; k < int'(STAGES); k++) begin
            stage_in[k] = decode_slice(data_q[k-1], int'(WIDTH) - 1 - k * CHUNK,
                                       int'(WIDTH) - (k + 1) * CHUNK);
            valid_in[k] = valid_q[k-1];
            err_in[k]   = err_q[k-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            valid_q    <= '0;
            err_q      <= '0;
            data_q     <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (en[k]) begin
                    valid_q[k] <= valid_in[k];
                    // Bubbles leave payload untouched so bin_out stays quiet when idle.
                    if (valid_in[k]) begin
                        data_q[k] <= stage_in[k];
                        err_q[k]  <= err_in[k];
                    end
                end
            end
            if (in_fire) begin
                prev_q     <= gray_in;
                prev_vld_q <= 1'b1;
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign bin_out   = data_q[STAGES-1];
    assign step_err  = err_q[STAGES-1];

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Bench for gray2bin_pipe: three instances (STAGES 1, 2, 8) checked against a
// scoreboard of expected decodes, step flags and latencies.
module tb_gray2bin_pipe;

    typedef struct {
        logic [7:0] bin;
        logic       err;
        int         cyc;
    } exp_t;

    typedef struct {
        logic       rst_first;
        logic [7:0] gray;
        logic [7:0] bin;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       iv  [3];
    logic       ir  [3];
    logic       ov  [3];
    logic       orr [3];
    logic       se  [3];
    logic [7:0] gi  [3];
    logic [7:0] bo  [3];

    exp_t       sb [3][$];
    logic [7:0] mprev   [3];
    logic       mprev_v [3];
    int         outs [3];
    int         total;
    int         bad;
    int         cyc;
    logic       lat_chk;
    logic       sent;
    vec_t       vecs [8];

    gray2bin_pipe #(.WIDTH(8), .STAGES(1)) u_s1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .gray_in(gi[0]), .out_valid(ov[0]), .out_ready(orr[0]), .bin_out(bo[0]),
        .step_err(se[0])
    );
    gray2bin_pipe #(.WIDTH(8), .STAGES(2)) u_s2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .gray_in(gi[1]), .out_valid(ov[1]), .out_ready(orr[1]), .bin_out(bo[1]),
        .step_err(se[1])
    );
    gray2bin_pipe #(.WIDTH(8), .STAGES(8)) u_s8 (
        .sys_clk(clk), .sys_rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .gray_in(gi[2]), .out_valid(ov[2]), .out_ready(orr[2]), .bin_out(bo[2]),
        .step_err(se[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int stg(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            default: return 8;
        endcase
    endfunction

    function automatic logic [7:0] to_gray(input int i);
        logic [7:0] v;
        v = i[7:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output side: compare on every output transfer, and hold value under stall.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d]) begin
                    if (sb[d].size() == 0) begin
                        chk("unexpected_output", {31'b0, ov[d]}, 32'd0);
                    end else if (orr[d]) begin
                        exp_t e;
                        e = sb[d].pop_front();
                        outs[d]++;
                        chk("bin_out", {24'b0, bo[d]}, {24'b0, e.bin});
                        chk("step_err", {31'b0, se[d]}, {31'b0, e.err});
                        if (lat_chk) chk("latency", cyc - e.cyc, stg(d));
                    end else begin
                        chk("hold_bin", {24'b0, bo[d]}, {24'b0, sb[d][0].bin});
                        chk("hold_err", {31'b0, se[d]}, {31'b0, sb[d][0].err});
                    end
                end
            end
        end
    end

    // Drive one sample; push its expectation at the cycle it is accepted.
    task automatic send(input int d, input logic [7:0] g, input logic [7:0] eb, input logic ee);
        int n;
        exp_t e;
        n = 0;
        gi[d] = g;
        iv[d] = 1'b1;
        @(negedge clk);
        while (!ir[d] && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ir[d]) begin
            chk("send_timeout", {31'b0, ir[d]}, 32'd1);
        end else begin
            e.bin = eb;
            e.err = ee;
            e.cyc = cyc;
            sb[d].push_back(e);
            mprev[d]   = g;
            mprev_v[d] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_model(input int d, input logic [7:0] g);
        logic ee;
        ee = mprev_v[d] && ($countones(g ^ mprev[d]) > 1);
        send(d, g, g2b(g), ee);
    endtask

    task automatic drain(input int d);
        int n;
        iv[d] = 1'b0;
        n = 0;
        while (sb[d].size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb[d].size(), 32'd0);
        @(negedge clk);
        chk("idle_out_valid", {31'b0, ov[d]}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            sb[d].delete();
            mprev_v[d] = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("rst_in_ready", {31'b0, ir[d]}, 32'd0);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_out_valid", {31'b0, ov[d]}, 32'd0);
            chk("rst_bin_out", {24'b0, bo[d]}, 32'd0);
            chk("rst_step_err", {31'b0, se[d]}, 32'd0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        lat_chk = 1'b0;
        sent    = 1'b0;
        rst_n   = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; orr[d] = 1'b1; gi[d] = 8'h00;
            mprev[d] = 8'h00; mprev_v[d] = 1'b0; outs[d] = 0;
        end
        vecs[0] = '{1'b1, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h01, 8'h01, 1'b0};
        vecs[2] = '{1'b0, 8'h03, 8'h02, 1'b0};
        vecs[3] = '{1'b0, 8'h02, 8'h03, 1'b0};
        vecs[4] = '{1'b0, 8'hC0, 8'h80, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 8'h03, 8'h02, 1'b1};
        vecs[7] = '{1'b0, 8'h03, 8'h02, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Directed vectors on the STAGES=2 instance, back-to-back within a group.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst_first) begin
                drain(1);
                do_reset();
            end
            send(1, vecs[v].gray, vecs[v].bin, vecs[v].err);
        end
        drain(1);

        // Full sweep plus wrap on every instance, latency checked per sample.
        for (int d = 0; d < 3; d++) begin
            do_reset();
            outs[d] = 0;
            lat_chk = 1'b1;
            for (int i = 0; i < 256; i++) send_model(d, to_gray(i));
            send_model(d, 8'h00);
            drain(d);
            lat_chk = 1'b0;
            chk("sweep_count", outs[d], 32'd257);
        end

        // Backpressure: stall, then random out_ready until all ten are out.
        do_reset();
        outs[1] = 0;
        orr[1]  = 1'b0;
        sent    = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_model(1, to_gray(i));
                iv[1] = 1'b0;
                sent  = 1'b1;
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_in_ready", {31'b0, ir[1]}, 32'd0);
                chk("bp_out_valid", {31'b0, ov[1]}, 32'd1);
                chk("bp_hold_zero", {24'b0, bo[1]}, 32'd0);
                n = 0;
                while ((!sent || sb[1].size() != 0) && n < 400) begin
                    @(posedge clk);
                    #1;
                    orr[1] = 1'($urandom_range(0, 1));
                    n++;
                end
                orr[1] = 1'b1;
            end
        join
        drain(1);
        chk("bp_count", outs[1], 32'd10);

        // Reset with two samples in flight, then a fresh sample.
        do_reset();
        send_model(1, 8'h00);
        send_model(1, 8'h01);
        do_reset();
        send(1, 8'hFF, 8'hAA, 1'b0);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
